// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU word sequencer and the bench-side ALU.
//   seq_state_e : sequencer FSM states (IDLE, ISSUE, RESP)
//   MODE_*      : alu_mode encodings (logic / carry-chained arithmetic)
//   alu_opsel_t : 3-bit operation select shared with the ALU slice
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  typedef logic [2:0] alu_opsel_t;

  localparam alu_opsel_t OP_ADD = 3'd0;
  localparam alu_opsel_t OP_SUB = 3'd1;
  localparam alu_opsel_t OP_AND = 3'd2;
  localparam alu_opsel_t OP_OR  = 3'd3;
  localparam alu_opsel_t OP_XOR = 3'd4;

endpackage

// File: rtl/alu_seq_word_mux.sv
// Selects DWIDTH-bit word `sel` (word 0 = least significant) out of a
// NWORDS*DWIDTH-bit vector. Out-of-range selects return 0.
//   vec  : wide input vector
//   sel  : word index
//   word : selected word
module alu_seq_word_mux #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NWORDS = 2,
  parameter int unsigned KW     = 1
) (
  input  logic [NWORDS*DWIDTH-1:0] vec,
  input  logic [KW-1:0]            sel,
  output logic [DWIDTH-1:0]        word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (sel == KW'(i)) begin
        word = vec[i*DWIDTH +: DWIDTH];
      end
    end
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// Command-side initiator for a DWIDTH-bit ALU slice. Accepts a wide
// (NWORDS x DWIDTH) operation, issues it to the ALU one word per cycle
// LSW first, chains carry in arithmetic mode, and returns the assembled
// result with carry/zero/sign flags on a valid/ready response channel.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cmd_*           : command channel (valid/ready, opsel, mode, cin, a, b)
//   alu_*           : word-serial interface to the combinational ALU
//   rsp_*           : response channel (valid/ready, result, carry, zero, sign)
module alu_word_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NWORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_opsel,
  input  logic                     cmd_mode,
  input  logic                     cmd_cin,
  input  logic [NWORDS*DWIDTH-1:0] cmd_a,
  input  logic [NWORDS*DWIDTH-1:0] cmd_b,
  output logic [DWIDTH-1:0]        alu_op1,
  output logic [DWIDTH-1:0]        alu_op2,
  output logic [2:0]               alu_opsel,
  output logic                     alu_mode,
  output logic                     alu_cin,
  input  logic [DWIDTH-1:0]        alu_result,
  input  logic                     alu_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NWORDS*DWIDTH-1:0] rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_sign
);

  localparam int unsigned W  = NWORDS * DWIDTH;
  localparam int unsigned KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  seq_state_e  state_q, state_d;
  alu_opsel_t  opsel_q, opsel_d;
  logic        mode_q, mode_d;
  logic        cin_q, cin_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;

  logic [DWIDTH-1:0] word_a;
  logic [DWIDTH-1:0] word_b;
  logic              issue;

  alu_seq_word_mux #(.DWIDTH(DWIDTH), .NWORDS(NWORDS), .KW(KW)) u_mux_a (
    .vec  (a_q),
    .sel  (k_q),
    .word (word_a)
  );

  alu_seq_word_mux #(.DWIDTH(DWIDTH), .NWORDS(NWORDS), .KW(KW)) u_mux_b (
    .vec  (b_q),
    .sel  (k_q),
    .word (word_b)
  );

  assign issue = (state_q == ISSUE);

  // ALU inputs are held at 0 outside ISSUE so the datapath stays quiescent.
  // carry_q holds the cout of word k-1 while word k is being issued.
  always_comb begin
    alu_op1   = issue ? word_a : '0;
    alu_op2   = issue ? word_b : '0;
    alu_opsel = issue ? opsel_q : '0;
    alu_mode  = issue ? mode_q : 1'b0;
    alu_cin   = 1'b0;
    if (issue && (mode_q == MODE_ARITH)) begin
      alu_cin = (k_q == '0) ? cin_q : carry_q;
    end
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RESP);
    rsp_result = rsp_valid ? res_q : '0;
    rsp_carry  = rsp_valid & (mode_q == MODE_ARITH) & carry_q;
    rsp_zero   = rsp_valid & zero_q;
    rsp_sign   = rsp_valid & res_q[W-1];
  end

  always_comb begin
    state_d = state_q;
    opsel_d = opsel_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opsel_d = cmd_opsel;
          mode_d  = cmd_mode;
          cin_d   = cmd_cin;
          a_d     = cmd_a;
          b_d     = cmd_b;
          k_d     = '0;
          zero_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        for (int unsigned i = 0; i < NWORDS; i++) begin
          if (k_q == KW'(i)) begin
            res_d[i*DWIDTH +: DWIDTH] = alu_result;
          end
        end
        carry_d = alu_cout;
        zero_d  = zero_q & (alu_result == '0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opsel_q <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opsel_q <= opsel_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_word_sequencer.sv
module tb_alu_word_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned W  = DW * NW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_opsel;
  logic          cmd_mode;
  logic          cmd_cin;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [2:0]    alu_opsel;
  logic          alu_mode;
  logic          alu_cin;
  logic [DW-1:0] alu_result;
  logic          alu_cout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          rsp_sign;

  alu_word_sequencer #(.DWIDTH(DW), .NWORDS(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opsel  (cmd_opsel),
    .cmd_mode   (cmd_mode),
    .cmd_cin    (cmd_cin),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit ripple ALU slice. In logic mode cout carries the result parity,
  // so a sequencer that fails to mask carry in logic mode is exposed.
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    if (alu_mode) begin
      alu_sum = {1'b0, alu_op1} + {1'b0, (alu_opsel == OP_SUB) ? ~alu_op2 : alu_op2}
                + {{DW{1'b0}}, alu_cin};
      alu_result = alu_sum[DW-1:0];
      alu_cout   = alu_sum[DW];
    end else begin
      case (alu_opsel)
        OP_AND:  alu_result = alu_op1 & alu_op2;
        OP_OR:   alu_result = alu_op1 | alu_op2;
        OP_XOR:  alu_result = alu_op1 ^ alu_op2;
        default: alu_result = alu_op1;
      endcase
      alu_cout = ^alu_result;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-width reference: {carry, result}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op, input logic mode, input logic cin);
    if (mode) begin
      return {1'b0, a} + {1'b0, (op == OP_SUB) ? ~b : b} + (W+1)'(cin);
    end
    case (op)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Carry into word w of the wide arithmetic sum: sum of the low w words.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [2:0] op, input logic cin, input int w);
    logic [W:0] mask;
    logic [W:0] t;
    logic [W-1:0] bb;
    if (w == 0) return cin;
    bb   = (op == OP_SUB) ? ~b : b;
    mask = ((W+1)'(1) << (w * DW)) - (W+1)'(1);
    t = {1'b0, a & mask[W-1:0]} + {1'b0, bb & mask[W-1:0]} + (W+1)'(cin);
    return t[w*DW];
  endfunction

  // Monitor/scoreboard: m_cyc = 0 idle, 1..NW issuing word m_cyc-1, NW+1 responding.
  int           cycle_no = 0;
  int           m_cyc = 0;
  int           mw;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_op;
  logic         m_mode, m_cin;
  logic [W:0]   m_exp;
  int           acc_times[$];
  logic [W:0]   rsp_log[$];

  always @(posedge clk) cycle_no++;

  always @(negedge clk) begin
    if (!rst_n) m_cyc = 0;
    chk("cmd_ready", cmd_ready, m_cyc == 0);
    chk("rsp_valid", rsp_valid, m_cyc == NW + 1);
    if (m_cyc >= 1 && m_cyc <= NW) begin
      mw = m_cyc - 1;
      chk("alu_op1", alu_op1, m_a[mw*DW +: DW]);
      chk("alu_op2", alu_op2, m_b[mw*DW +: DW]);
      chk("alu_ctl", {alu_opsel, alu_mode}, {m_op, m_mode});
      chk("alu_cin", alu_cin, m_mode ? carry_into(m_a, m_b, m_op, m_cin, mw) : 1'b0);
    end else begin
      chk("alu_quiet", {alu_op1, alu_op2, alu_opsel, alu_mode, alu_cin}, '0);
    end
    if (m_cyc == NW + 1) begin
      chk("rsp_result", rsp_result, m_exp[W-1:0]);
      chk("rsp_carry", rsp_carry, m_exp[W]);
      chk("rsp_zero", rsp_zero, m_exp[W-1:0] == '0);
      chk("rsp_sign", rsp_sign, m_exp[W-1]);
    end
    if (rst_n) begin
      if (m_cyc == 0) begin
        if (cmd_valid) begin
          m_a = cmd_a; m_b = cmd_b; m_op = cmd_opsel; m_mode = cmd_mode; m_cin = cmd_cin;
          m_exp = ref_op(cmd_a, cmd_b, cmd_opsel, cmd_mode, cmd_cin);
          acc_times.push_back(cycle_no + 1);
          m_cyc = 1;
        end
      end else if (m_cyc <= NW) begin
        m_cyc++;
      end else if (rsp_ready) begin
        rsp_log.push_back({rsp_carry, rsp_result});
        m_cyc = 0;
      end
    end
  end

  // Drive a command; returns one time step after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic mode, input logic cin);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opsel = op; cmd_mode = mode; cmd_cin = cin;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", n < 50, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
    cmd_opsel = 3'($urandom); cmd_mode = 1'($urandom); cmd_cin = 1'($urandom);
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("rsp_wait", edges < 50, 1'b1);
  endtask

  task automatic take_rsp(output logic [W-1:0] r, output logic c, output logic z, output logic s);
    r = rsp_result; c = rsp_carry; z = rsp_zero; s = rsp_sign;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e, nlog, nacc, nops;
    logic [W-1:0] r, r0;
    logic c, z, s, c0, z0, s0;
    logic [W-1:0] ra, rb;
    logic rmode;
    logic [2:0] rop;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opsel = '0; cmd_mode = 1'b0; cmd_cin = 1'b0;
    cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    #1;
    chk("reset_outputs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, alu_op1, alu_op2}, '0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Carry across words.
    send(64'h00000000_FFFFFFFF, 64'h1, OP_ADD, MODE_ARITH, 1'b0);
    wait_rsp(e);
    chk("t1_rsp_cycle", e + 1, 3);
    take_rsp(r, c, z, s);
    chk("t1_result", r, 64'h00000001_00000000);
    chk("t1_flags", {c, z, s}, 3'b000);

    // Full wrap.
    send(64'hFFFFFFFF_FFFFFFFF, 64'h1, OP_ADD, MODE_ARITH, 1'b0);
    wait_rsp(e);
    take_rsp(r, c, z, s);
    chk("t2_result", r, 64'h0);
    chk("t2_flags", {c, z, s}, 3'b110);

    // Logic mode ignores cin.
    send(64'hF0F0F0F0_0F0F0F0F, 64'hFFFF0000_FFFF0000, OP_AND, MODE_LOGIC, 1'b1);
    for (int i = 0; i < int'(NW); i++) begin
      chk("t3_alu_cin", alu_cin, 1'b0);
      @(posedge clk); #1;
    end
    wait_rsp(e);
    take_rsp(r, c, z, s);
    chk("t3_result", r, 64'hF0F00000_0F0F0000);
    chk("t3_flags", {c, z, s}, 3'b001);

    // Backpressure.
    send(64'h80000000_00000000, 64'h80000000_00000001, OP_SUB, MODE_ARITH, 1'b1);
    wait_rsp(e);
    r0 = rsp_result; c0 = rsp_carry; z0 = rsp_zero; s0 = rsp_sign;
    chk("t4_result", r0, 64'hFFFFFFFF_FFFFFFFF);
    chk("t4_flags", {c0, z0, s0}, 3'b001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_stable", {rsp_valid, cmd_ready, rsp_result, rsp_carry, rsp_zero, rsp_sign},
          {1'b1, 1'b0, r0, c0, z0, s0});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t4_release", {rsp_valid, cmd_ready}, 2'b01);

    // Reset during ISSUE word 0.
    send(64'h12345678_9ABCDEF0, 64'h11111111_11111111, OP_ADD, MODE_ARITH, 1'b0);
    chk("t5_issuing", alu_op1, 32'h9ABCDEF0);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_now", {alu_op1, alu_op2, alu_opsel, alu_mode, alu_cin, rsp_valid, rsp_result},
        '0);
    chk("t5_reset_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_no_rsp", rsp_valid, 1'b0);
    end
    send(64'h12345678_9ABCDEF0, 64'h11111111_11111111, OP_ADD, MODE_ARITH, 1'b0);
    wait_rsp(e);
    take_rsp(r, c, z, s);
    chk("t5_result", r, 64'h23456789_ABCDF001);
    chk("t5_flags", {c, z, s}, 3'b000);

    // Back-to-back with cmd_valid held and rsp_ready held.
    nlog = rsp_log.size(); nacc = acc_times.size();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 64'd5; cmd_b = 64'd7; cmd_opsel = OP_ADD; cmd_mode = MODE_ARITH;
    cmd_cin = 1'b0;
    @(posedge clk); #1;
    cmd_a = 64'd10; cmd_b = 64'd3; cmd_opsel = OP_SUB; cmd_cin = 1'b1;
    e = 0;
    while (!cmd_ready && e < 50) begin
      @(posedge clk); #1;
      e++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (NW + 3) @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("t6_accepts", acc_times.size() - nacc, 2);
    chk("t6_spacing", acc_times[nacc+1] - acc_times[nacc], NW + 2);
    chk("t6_rsps", rsp_log.size() - nlog, 2);
    chk("t6_first", rsp_log[nlog], {1'b0, 64'd12});
    chk("t6_second", rsp_log[nlog+1], {1'b1, 64'd7});

    // Randomized operations.
    nops = rsp_log.size();
    for (int i = 0; i < 200; i++) begin
      rmode = 1'($urandom);
      rop = rmode ? ((($urandom % 2) == 0) ? OP_ADD : OP_SUB)
                  : 3'(OP_AND + 3'($urandom_range(0, 2)));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '0;
        2: rb = ra;
        3: ra = {32'h0, $urandom};
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
      end
      send(ra, rb, rop, rmode, 1'($urandom));
      wait_rsp(e);
      chk("rand_latency", e, NW);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      take_rsp(r, c, z, s);
    end
    chk("rand_count", rsp_log.size() - nops, 200);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
